// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART state encodings and frame constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      s_IDLE         = 3'd0,
      s_RX_START_BIT = 3'd1,
      s_RX_DATA_BITS = 3'd2,
      s_RX_STOP_BIT  = 3'd3,
      s_CLEAN_UP     = 3'd4
   } uart_state_e;

   localparam int CLKS_PER_BIT_DEFAULT = 87;
   localparam int FRAME_BITS           = 8;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : two-flop synchroniser with a previous-value flop for edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_Async,
   output logic o_Rx_Sync,
   output logic o_Fall_Edge
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = i_Async;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Resetting to 1 matches the idle line, so no false edge appears out of reset.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign o_Rx_Sync   = sync_q;
   assign o_Fall_Edge = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx : 8N1 UART receiver, mid-bit sampling, 1-cycle DV / frame-error strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Frame_Err,
   output logic       o_Rx_Active
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic rx_sync;
   logic rx_fall;

   uart_rx_sync u_sync (
      .i_Clock     (i_Clock),
      .i_Rst_n     (i_Rst_n),
      .i_Async     (i_Rx_Serial),
      .o_Rx_Sync   (rx_sync),
      .o_Fall_Edge (rx_fall)
   );

   uart_state_e           state_q,  state_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [IDX_W-1:0]      idx_q,    idx_d;
   logic [FRAME_BITS-1:0] shift_q,  shift_d;
   logic [7:0]            byte_q,   byte_d;
   logic                  dv_q,     dv_d;
   logic                  ferr_q,   ferr_d;
   logic                  active_q, active_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      dv_d     = dv_q;
      ferr_d   = ferr_q;
      active_d = active_q;

      case (state_q)
         s_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            // Only a genuine high-to-low transition starts a frame; a held-low line does not.
            if (rx_fall) begin
               state_d = s_RX_START_BIT;
            end
         end

         s_RX_START_BIT: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d  = s_RX_DATA_BITS;
                  active_d = 1'b1;
               end else begin
                  state_d = s_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         s_RX_DATA_BITS: begin
            if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_sync;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = s_RX_STOP_BIT;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end

         s_RX_STOP_BIT: begin
            if (cnt_q < CNT_LAST) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d    = '0;
               active_d = 1'b0;
               state_d  = s_CLEAN_UP;
               if (rx_sync) begin
                  byte_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end

         s_CLEAN_UP: begin
            dv_d    = 1'b0;
            ferr_d  = 1'b0;
            state_d = s_IDLE;
         end

         default: begin
            state_d = s_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q  <= s_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         byte_q   <= 8'h00;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         ferr_q   <= ferr_d;
         active_q <= active_d;
      end
   end

   assign o_Rx_DV        = dv_q;
   assign o_Rx_Byte      = byte_q;
   assign o_Rx_Frame_Err = ferr_q;
   assign o_Rx_Active    = active_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx at 16 and 87 clocks per bit
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

   localparam int  CPB      = 16;
   localparam int  CPB_SLOW = 87;
   localparam real T_CLK    = 10.0;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx16  = 1'b1;
   logic       rx87  = 1'b1;
   logic       dv16, ferr16, act16;
   logic [7:0] byte16;
   logic       dv87, ferr87, act87;
   logic [7:0] byte87;

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clock        (clk),
      .i_Rst_n        (rst_n),
      .i_Rx_Serial    (rx16),
      .o_Rx_DV        (dv16),
      .o_Rx_Byte      (byte16),
      .o_Rx_Frame_Err (ferr16),
      .o_Rx_Active    (act16)
   );

   uart_rx #(.CLKS_PER_BIT(CPB_SLOW)) dut87 (
      .i_Clock        (clk),
      .i_Rst_n        (rst_n),
      .i_Rx_Serial    (rx87),
      .o_Rx_DV        (dv87),
      .o_Rx_Byte      (byte87),
      .o_Rx_Frame_Err (ferr87),
      .o_Rx_Active    (act87)
   );

   int         n_checks    = 0;
   int         n_pass      = 0;
   int         cyc         = 0;
   int         dv_cnt      = 0;
   int         ferr_cnt    = 0;
   int         act_cnt     = 0;
   int         dv87_cnt    = 0;
   int         last_dv_cyc = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp87_q[$];
   logic [7:0] e16, e87;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every DV pops the oldest expected byte.
   always @(negedge clk) begin
      if (act16)  act_cnt++;
      if (ferr16) ferr_cnt++;
      if (dv16 || ferr16) begin
         n_checks++;
         if (dv16 && ferr16)
            $display("FAIL strobe_overlap: dv=%b ferr=%b, required never both high", dv16, ferr16);
         else
            n_pass++;
      end
      if (dv16) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL rx16_byte: unexpected DV with byte %h, none expected", byte16);
         end else begin
            e16 = exp_q.pop_front();
            if (byte16 !== e16)
               $display("FAIL rx16_byte: got %h, expected %h", byte16, e16);
            else
               n_pass++;
         end
      end
      if (dv87) begin
         dv87_cnt++;
         n_checks++;
         if (exp87_q.size() == 0) begin
            $display("FAIL rx87_byte: unexpected DV with byte %h, none expected", byte87);
         end else begin
            e87 = exp87_q.pop_front();
            if (byte87 !== e87)
               $display("FAIL rx87_byte: got %h, expected %h", byte87, e87);
            else
               n_pass++;
         end
      end
   end

   task automatic hold16(input logic v, input int n);
      rx16 = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send16(input logic [7:0] b, input logic stop_v);
      if (stop_v) exp_q.push_back(b);
      hold16(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold16(b[i], CPB);
      hold16(stop_v, CPB);
   endtask

   task automatic send87(input logic [7:0] b, input real bit_ns);
      exp87_q.push_back(b);
      rx87 = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx87 = b[i];
         #(bit_ns);
      end
      rx87 = 1'b1;
      #(bit_ns);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx16  = 1'b1;
      rx87  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (dv16 !== 1'b0)     $display("FAIL reset_dv: got %b, expected 0", dv16);       else n_pass++;
      n_checks++; if (byte16 !== 8'h00)  $display("FAIL reset_byte: got %h, expected 00", byte16);  else n_pass++;
      n_checks++; if (ferr16 !== 1'b0)   $display("FAIL reset_ferr: got %b, expected 0", ferr16);   else n_pass++;
      n_checks++; if (act16 !== 1'b0)    $display("FAIL reset_active: got %b, expected 0", act16);  else n_pass++;
      n_checks++; if (byte87 !== 8'h00)  $display("FAIL reset_byte87: got %h, expected 00", byte87); else n_pass++;
      rst_n = 1'b1;
      hold16(1'b1, 4);
   endtask

   task automatic test_single();
      int d0, f0, a0, t0, lat, act;
      d0 = dv_cnt; f0 = ferr_cnt; a0 = act_cnt;
      @(posedge clk); #1;
      t0 = cyc;
      send16(8'hA5, 1'b1);
      hold16(1'b1, CPB);
      lat = last_dv_cyc - t0;
      act = act_cnt - a0;
      n_checks++; if (dv_cnt - d0 !== 1)   $display("FAIL single_dv_count: got %0d, expected 1", dv_cnt - d0);  else n_pass++;
      n_checks++; if (byte16 !== 8'hA5)    $display("FAIL single_byte: got %h, expected a5", byte16);           else n_pass++;
      n_checks++; if (ferr_cnt - f0 !== 0) $display("FAIL single_ferr: got %0d, expected 0", ferr_cnt - f0);   else n_pass++;
      n_checks++; if (act < 140 || act > 148) $display("FAIL single_active_len: got %0d, expected 140..148", act); else n_pass++;
      n_checks++; if (lat < 153 || lat > 157) $display("FAIL single_latency: got %0d, expected 153..157", lat);   else n_pass++;
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = dv_cnt;
      @(posedge clk); #1;
      send16(8'h00, 1'b1);
      send16(8'hFF, 1'b1);
      hold16(1'b1, 2 * CPB);
      n_checks++; if (dv_cnt - d0 !== 2)    $display("FAIL b2b_dv_count: got %0d, expected 2", dv_cnt - d0);    else n_pass++;
      n_checks++; if (exp_q.size() !== 0)   $display("FAIL b2b_pending: got %0d, expected 0", exp_q.size());    else n_pass++;
      n_checks++; if (byte16 !== 8'hFF)     $display("FAIL b2b_last_byte: got %h, expected ff", byte16);        else n_pass++;
   endtask

   task automatic test_glitch();
      int d0, f0, a0;
      d0 = dv_cnt; f0 = ferr_cnt; a0 = act_cnt;
      @(posedge clk); #1;
      hold16(1'b0, 5);
      hold16(1'b1, 3 * CPB);
      n_checks++; if (dv_cnt - d0 !== 0)   $display("FAIL glitch_dv: got %0d, expected 0", dv_cnt - d0);       else n_pass++;
      n_checks++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_ferr: got %0d, expected 0", ferr_cnt - f0);   else n_pass++;
      n_checks++; if (act_cnt - a0 !== 0)  $display("FAIL glitch_active: got %0d, expected 0", act_cnt - a0);  else n_pass++;
   endtask

   task automatic test_frame_err();
      int d0, f0;
      d0 = dv_cnt; f0 = ferr_cnt;
      @(posedge clk); #1;
      send16(8'h3C, 1'b0);
      hold16(1'b0, 3 * CPB);
      n_checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_count: got %0d, expected 1", ferr_cnt - f0);    else n_pass++;
      n_checks++; if (dv_cnt - d0 !== 0)   $display("FAIL ferr_dv: got %0d, expected 0", dv_cnt - d0);         else n_pass++;
      n_checks++; if (byte16 !== 8'hFF)    $display("FAIL ferr_byte_kept: got %h, expected ff", byte16);       else n_pass++;
      n_checks++; if (act16 !== 1'b0)      $display("FAIL ferr_active: got %b, expected 0", act16);            else n_pass++;
      hold16(1'b1, 3 * CPB);
      n_checks++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_no_refire: got %0d, expected 1", ferr_cnt - f0); else n_pass++;
      n_checks++; if (dv_cnt - d0 !== 0)   $display("FAIL ferr_no_dv: got %0d, expected 0", dv_cnt - d0);      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      int d0;
      b = 8'h81;
      @(posedge clk); #1;
      hold16(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold16(b[i], CPB);
      hold16(b[4], CPB / 2);
      n_checks++; if (act16 !== 1'b1) $display("FAIL midrst_active_before: got %b, expected 1", act16); else n_pass++;
      d0 = dv_cnt;
      rst_n = 1'b0;
      #1;
      n_checks++; if (dv16 !== 1'b0)    $display("FAIL midrst_dv: got %b, expected 0", dv16);        else n_pass++;
      n_checks++; if (byte16 !== 8'h00) $display("FAIL midrst_byte: got %h, expected 00", byte16);   else n_pass++;
      n_checks++; if (ferr16 !== 1'b0)  $display("FAIL midrst_ferr: got %b, expected 0", ferr16);    else n_pass++;
      n_checks++; if (act16 !== 1'b0)   $display("FAIL midrst_active: got %b, expected 0", act16);   else n_pass++;
      hold16(1'b1, 3);
      rst_n = 1'b1;
      hold16(1'b1, 2 * CPB);
      send16(b, 1'b1);
      hold16(1'b1, CPB);
      n_checks++; if (dv_cnt - d0 !== 1) $display("FAIL midrst_dv_count: got %0d, expected 1", dv_cnt - d0); else n_pass++;
      n_checks++; if (byte16 !== 8'h81)  $display("FAIL midrst_rx_byte: got %h, expected 81", byte16);      else n_pass++;
   endtask

   task automatic test_skew();
      int d0;
      real nominal;
      d0      = dv87_cnt;
      nominal = CPB_SLOW * T_CLK;
      send87(8'h5A, nominal * 1.03);
      #(nominal * 2.0);
      send87(8'h5A, nominal * 0.97);
      #(nominal * 2.0);
      n_checks++; if (dv87_cnt - d0 !== 2)  $display("FAIL skew_dv_count: got %0d, expected 2", dv87_cnt - d0);  else n_pass++;
      n_checks++; if (byte87 !== 8'h5A)     $display("FAIL skew_byte: got %h, expected 5a", byte87);             else n_pass++;
      n_checks++; if (exp87_q.size() !== 0) $display("FAIL skew_pending: got %0d, expected 0", exp87_q.size());  else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_skew();
      n_checks++;
      if (exp_q.size() !== 0)
         $display("FAIL final_pending: got %0d, expected 0", exp_q.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
